// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: memory-stage capture inputs plus the register-file write port
// and status outputs driven by the WB pipeline register.
interface mem_wb_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     stall;
  logic                     flush;
  logic                     mem_valid;
  logic                     mem_rg_wrt_en;
  logic [ADDRESS_WIDTH-1:0] mem_rg_wrt_dest;
  logic [1:0]               mem_wb_sel;
  logic [2:0]               mem_funct3;
  logic [DATA_WIDTH-1:0]    mem_alu_result;
  logic [DATA_WIDTH-1:0]    mem_pc_plus4;
  logic [DATA_WIDTH-1:0]    mem_rd_data;

  logic                     wb_valid;
  logic                     rg_wrt_en;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
  logic [DATA_WIDTH-1:0]    rg_wrt_data;
  logic                     load_fault;
  logic [31:0]              retire_count;

  modport master (
    output stall, flush, mem_valid, mem_rg_wrt_en, mem_rg_wrt_dest, mem_wb_sel,
           mem_funct3, mem_alu_result, mem_pc_plus4, mem_rd_data,
    input  wb_valid, rg_wrt_en, rg_wrt_dest, rg_wrt_data, load_fault, retire_count
  );

  modport slave (
    input  stall, flush, mem_valid, mem_rg_wrt_en, mem_rg_wrt_dest, mem_wb_sel,
           mem_funct3, mem_alu_result, mem_pc_plus4, mem_rd_data,
    output wb_valid, rg_wrt_en, rg_wrt_dest, rg_wrt_data, load_fault, retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, flags illegal/misaligned loads,
// drives the register-file write port and counts retired instructions.
module mem_wb_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input logic             clk,
  input logic             rst,
  mem_wb_stage_if.slave   bus
);

  typedef struct packed {
    logic                     wen;
    logic [ADDRESS_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]    data;
  } wb_t;

  logic [1:0]            off;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  misaligned, illegal, fault;
  wb_t                   wb_nxt, wb_q;
  logic [1:0]            vld_pipe;
  logic                  fault_q;
  logic [31:0]           retire_q;

  assign off         = bus.mem_alu_result[1:0];
  assign byte_sel    = bus.mem_rd_data[{off, 3'b000} +: 8];
  assign half_sel    = off[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
  assign vld_pipe[0] = bus.mem_valid;

  always_comb begin
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (bus.mem_funct3)
      3'b000: load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b001: begin
        load_data  = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      3'b101: begin
        load_data  = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        misaligned = off[0];
      end
      3'b010: begin
        load_data  = bus.mem_rd_data;
        misaligned = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Only a real load selection can fault; funct3 is meaningless for other wb_sel values.
  assign fault = (bus.mem_wb_sel == 2'b01) && (misaligned || illegal);

  always_comb begin
    wb_nxt      = '0;
    wb_nxt.wen  = bus.mem_valid & bus.mem_rg_wrt_en & (bus.mem_rg_wrt_dest != '0) & ~fault;
    wb_nxt.dest = bus.mem_rg_wrt_dest;
    case (bus.mem_wb_sel)
      2'b01:   wb_nxt.data = load_data;
      2'b10:   wb_nxt.data = bus.mem_pc_plus4;
      default: wb_nxt.data = bus.mem_alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q        <= '0;
      vld_pipe[1] <= 1'b0;
      fault_q     <= 1'b0;
      retire_q    <= '0;
    end else if (bus.flush) begin
      wb_q        <= '0;
      vld_pipe[1] <= 1'b0;
      fault_q     <= 1'b0;
    end else if (bus.stall) begin
      // Fault is a pulse: holding the stage must not replay it.
      fault_q <= 1'b0;
    end else begin
      wb_q        <= wb_nxt;
      vld_pipe[1] <= vld_pipe[0];
      fault_q     <= bus.mem_valid & fault;
      if (bus.mem_valid && !fault)
        retire_q <= retire_q + 32'd1;
    end
  end

  assign bus.wb_valid     = vld_pipe[1];
  assign bus.rg_wrt_en    = wb_q.wen;
  assign bus.rg_wrt_dest  = wb_q.dest;
  assign bus.rg_wrt_data  = wb_q.data;
  assign bus.load_fault   = fault_q;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized + directed bench for mem_wb_stage against an arithmetic reference model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  mem_wb_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();
  mem_wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference state
  logic        m_valid, m_wen, m_fault, m_dc;
  logic [4:0]  m_dest;
  logic [31:0] m_data, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int unsigned off;
    logic [31:0] b, h;
    off = a % 4;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  // Predict the stage after the coming rising edge from the inputs currently driven.
  task automatic model_step();
    int unsigned off;
    logic mis, ill, f;
    off = bus.mem_alu_result % 4;
    mis = ((bus.mem_funct3 == 3'd1 || bus.mem_funct3 == 3'd5) && (off % 2 == 1)) ||
          (bus.mem_funct3 == 3'd2 && off != 0);
    ill = bus.mem_funct3 inside {3'd3, 3'd6, 3'd7};
    f   = (bus.mem_wb_sel == 2'd1) && (mis || ill);
    if (bus.flush) begin
      m_valid = 0; m_wen = 0; m_fault = 0; m_dest = 0; m_data = 0; m_dc = 0;
    end else if (bus.stall) begin
      m_fault = 0;
    end else begin
      m_valid = bus.mem_valid;
      m_wen   = bus.mem_valid && bus.mem_rg_wrt_en && bus.mem_rg_wrt_dest != 0 && !f;
      m_dest  = bus.mem_rg_wrt_dest;
      m_dc    = (bus.mem_wb_sel == 2'd1) && ill;
      m_data  = (bus.mem_wb_sel == 2'd1) ? fmt(bus.mem_funct3, bus.mem_alu_result, bus.mem_rd_data) :
                (bus.mem_wb_sel == 2'd2) ? bus.mem_pc_plus4 : bus.mem_alu_result;
      m_fault = bus.mem_valid && f;
      if (bus.mem_valid && !f) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(m_valid));
    chk({tag, ".wen"},   32'(bus.rg_wrt_en), 32'(m_wen));
    chk({tag, ".dest"},  32'(bus.rg_wrt_dest), 32'(m_dest));
    if (!m_dc) chk({tag, ".data"}, bus.rg_wrt_data, m_data);
    chk({tag, ".fault"}, 32'(bus.load_fault), 32'(m_fault));
    chk({tag, ".cnt"},   bus.retire_count, m_cnt);
  endtask

  // Inputs are set at a falling edge; this advances one cycle and checks at the next falling edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] d, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] rd);
    bus.mem_valid = v; bus.mem_rg_wrt_en = we; bus.mem_rg_wrt_dest = d; bus.mem_wb_sel = sel;
    bus.mem_funct3 = f3; bus.mem_alu_result = alu; bus.mem_pc_plus4 = pc4; bus.mem_rd_data = rd;
  endtask

  task automatic model_reset();
    m_valid = 0; m_wen = 0; m_fault = 0; m_dest = 0; m_data = 0; m_cnt = 0; m_dc = 0;
  endtask

  localparam logic [31:0] W = 32'h80F1_7F82;

  initial begin
    logic [31:0] cnt_snap;
    model_reset();
    bus.stall = 0; bus.flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all("rst0");
    rst = 1'b1;

    // load formatting
    drive(1, 1, 5'd3, 2'd1, 3'd0, 32'h100, 0, W); tick("lb");
    chk("lb.const", bus.rg_wrt_data, 32'hFFFF_FF82);
    drive(1, 1, 5'd4, 2'd1, 3'd4, 32'h101, 0, W); tick("lbu");
    chk("lbu.const", bus.rg_wrt_data, 32'h0000_007F);
    drive(1, 1, 5'd5, 2'd1, 3'd1, 32'h102, 0, W); tick("lh");
    chk("lh.const", bus.rg_wrt_data, 32'hFFFF_80F1);
    drive(1, 1, 5'd6, 2'd1, 3'd5, 32'h102, 0, W); tick("lhu");
    chk("lhu.const", bus.rg_wrt_data, 32'h0000_80F1);
    drive(1, 1, 5'd7, 2'd1, 3'd2, 32'h100, 0, W); tick("lw");
    chk("lw.const", bus.rg_wrt_data, 32'h80F1_7F82);

    // misaligned LW faults: pulse, no write, no retire
    cnt_snap = m_cnt;
    drive(1, 1, 5'd8, 2'd1, 3'd2, 32'h1002, 0, W); tick("lwmis");
    chk("lwmis.fault", 32'(bus.load_fault), 1);
    chk("lwmis.wen", 32'(bus.rg_wrt_en), 0);
    chk("lwmis.valid", 32'(bus.wb_valid), 1);
    chk("lwmis.cnt", bus.retire_count, cnt_snap);
    bus.stall = 1; tick("fstall");
    chk("fstall.fault", 32'(bus.load_fault), 0);
    chk("fstall.valid", 32'(bus.wb_valid), 1);
    bus.stall = 0;
    drive(1, 1, 5'd9, 2'd1, 3'd3, 32'h1000, 0, W); tick("f3ill");
    chk("f3ill.fault", 32'(bus.load_fault), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("fclr");

    // x0 and PC+4 select
    cnt_snap = m_cnt;
    drive(1, 1, 5'd0, 2'd0, 3'd0, 32'h55, 0, 0); tick("x0");
    chk("x0.wen", 32'(bus.rg_wrt_en), 0);
    chk("x0.cnt", bus.retire_count, cnt_snap + 1);
    drive(1, 1, 5'd1, 2'd2, 3'd0, 32'hDEAD, 32'h124, 0); tick("pc4");
    chk("pc4.const", bus.rg_wrt_data, 32'h124);

    // 3-cycle stall freezes everything; stall+flush gives a bubble
    cnt_snap = m_cnt;
    bus.stall = 1;
    drive(1, 1, 5'd2, 2'd0, 3'd0, 32'h777, 0, 0);
    repeat (3) tick("stall");
    chk("stall.data", bus.rg_wrt_data, 32'h124);
    chk("stall.cnt", bus.retire_count, cnt_snap);
    bus.flush = 1; tick("sflush");
    chk("sflush.valid", 32'(bus.wb_valid), 0);
    chk("sflush.wen", 32'(bus.rg_wrt_en), 0);
    bus.stall = 0; bus.flush = 0;

    // asynchronous reset mid-cycle, in-flight instruction dropped
    drive(1, 1, 5'd10, 2'd0, 3'd0, 32'h42, 0, 0); tick("prerst");
    drive(1, 1, 5'd11, 2'd0, 3'd0, 32'h43, 0, 0);
    #2 rst = 1'b0;
    #1 model_reset(); check_all("arst");
    @(posedge clk); @(negedge clk);
    check_all("rsthold");
    rst = 1'b1;

    // counter wrap: preload near the top
    force dut.retire_q = 32'hFFFF_FFFE;
    #1 release dut.retire_q;
    m_cnt = 32'hFFFF_FFFE;
    drive(1, 1, 5'd1, 2'd0, 3'd0, 1, 0, 0); tick("wrap1");
    drive(1, 1, 5'd1, 2'd0, 3'd0, 2, 0, 0); tick("wrap2");
    chk("wrap.const", bus.retire_count, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.stall = ($urandom_range(7) == 0);
      bus.flush = ($urandom_range(9) == 0);
      drive($urandom_range(3) != 0, $urandom_range(1), 5'($urandom_range(31)),
            2'($urandom_range(3)), 3'($urandom_range(7)),
            ($urandom_range(3) == 0) ? $urandom : {$urandom_range(255), 2'($urandom_range(3))},
            $urandom, $urandom);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
